// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with stall, flush, valid tag; optional load-use detect via ID_EX_LOAD_USE_EN
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic              id_RegWrite,
  input  logic              id_MemtoReg,
  input  logic              id_MemRead,
  input  logic              id_MemWrite,
  input  logic              id_Branch,
  input  logic              id_ALUSrc,
  input  logic              id_RegDst,
  input  logic [1:0]        id_ALUOp,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  output logic              ex_valid,
  output logic              ex_RegWrite,
  output logic              ex_MemtoReg,
  output logic              ex_MemRead,
  output logic              ex_MemWrite,
  output logic              ex_Branch,
  output logic              ex_ALUSrc,
  output logic              ex_RegDst,
  output logic [1:0]        ex_ALUOp,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [5:0]        ex_funct,
  output logic              stall_out
);
  localparam int W = 10 + 4 * DATA_W + 3 * REG_W;
  logic [W-1:0] d, q;
  logic bubble;
`ifdef ID_EX_LOAD_USE_EN
  assign stall_out = ex_valid & ex_MemRead & (ex_rt != '0) & id_valid &
                     ((ex_rt == id_rs) | ((ex_rt == id_rt) & ~id_ALUSrc));
`else
  assign stall_out = 1'b0;
`endif
  assign bubble = flush | stall_out;
  // invalid slots keep their data but lose every control bit
  assign d = {id_valid,
              {9{id_valid}} & {id_RegWrite, id_MemtoReg, id_MemRead, id_MemWrite,
                               id_Branch, id_ALUSrc, id_RegDst, id_ALUOp},
              id_pc4, id_rdata1, id_rdata2, id_imm, id_rs, id_rt, id_rd};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (bubble) q <= '0;
    else if (!stall) q <= d;
  assign {ex_valid, ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite, ex_Branch,
          ex_ALUSrc, ex_RegDst, ex_ALUOp, ex_pc4, ex_rdata1, ex_rdata2, ex_imm,
          ex_rs, ex_rt, ex_rd} = q;
  assign ex_funct = ex_imm[5:0];
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: directed + reference-model check of id_ex_pipe_reg
module tb_id_ex_pipe_reg;
`ifdef ID_EX_LOAD_USE_EN
  localparam bit LU = 1'b1;
`else
  localparam bit LU = 1'b0;
`endif
  typedef struct packed {
    logic        valid, rw, mtr, mr, mw, br, as, rdst;
    logic [1:0]  op;
    logic [31:0] pc4, r1, r2, imm;
    logic [4:0]  rs, rt, rd;
  } ent_t;

  logic clk = 0, rst_n = 0, stall = 0, flush = 0;
  ent_t id, m, dut_e;
  logic ex_valid, ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite, ex_Branch, ex_ALUSrc, ex_RegDst;
  logic [1:0] ex_ALUOp;
  logic [31:0] ex_pc4, ex_rdata1, ex_rdata2, ex_imm;
  logic [4:0] ex_rs, ex_rt, ex_rd;
  logic [5:0] ex_funct;
  logic stall_out;
  int checks = 0, errors = 0;
  bit run = 1;

  always #5 clk = ~clk;

  id_ex_pipe_reg dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id.valid),
    .id_RegWrite(id.rw), .id_MemtoReg(id.mtr), .id_MemRead(id.mr), .id_MemWrite(id.mw),
    .id_Branch(id.br), .id_ALUSrc(id.as), .id_RegDst(id.rdst), .id_ALUOp(id.op),
    .id_pc4(id.pc4), .id_rdata1(id.r1), .id_rdata2(id.r2), .id_imm(id.imm),
    .id_rs(id.rs), .id_rt(id.rt), .id_rd(id.rd),
    .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_MemtoReg(ex_MemtoReg),
    .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_Branch(ex_Branch),
    .ex_ALUSrc(ex_ALUSrc), .ex_RegDst(ex_RegDst), .ex_ALUOp(ex_ALUOp),
    .ex_pc4(ex_pc4), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct), .stall_out(stall_out)
  );

  assign dut_e = {ex_valid, ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite, ex_Branch,
                  ex_ALUSrc, ex_RegDst, ex_ALUOp, ex_pc4, ex_rdata1, ex_rdata2, ex_imm,
                  ex_rs, ex_rt, ex_rd};

  // a load in EX whose destination is read by the valid instruction in ID
  function automatic logic load_use(ent_t ex, ent_t i);
    if (!LU || !ex.valid || !ex.mr || ex.rt == 0 || !i.valid) return 1'b0;
    return ex.rt == i.rs || (ex.rt == i.rt && !i.as);
  endfunction

  function automatic ent_t next_entry(ent_t cur, ent_t i, logic st, logic fl);
    ent_t e;
    if (fl || load_use(cur, i)) return '0;
    if (st) return cur;
    e = i;
    if (!i.valid) {e.rw, e.mtr, e.mr, e.mw, e.br, e.as, e.rdst, e.op} = '0;
    return e;
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) m <= '0;
    else m <= next_entry(m, id, stall, flush);

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (run) begin
      chk("model_entry", dut_e, m);
      chk("model_funct", ex_funct, m.imm[5:0]);
      chk("model_stall_out", stall_out, load_use(m, id));
    end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    id = '{valid: 1, rw: 1, mtr: 1, mr: 1, mw: 1, br: 1, as: 1, rdst: 1, op: 2'b11,
           pc4: 32'hFFFF_FFFF, r1: 32'h1234_5678, r2: 32'h9ABC_DEF0, imm: 32'hFFFF_FFFF,
           rs: 5'd31, rt: 5'd30, rd: 5'd29};
    tick; tick;
    chk("reset_entry", dut_e, 0);
    chk("reset_stall_out", stall_out, 0);
    rst_n = 1;
    id = '0;
    id.valid = 1; id.rw = 1; id.op = 2'b10; id.imm = 32'h2A; id.r1 = 32'h5; id.r2 = 32'h3;
    id.rs = 5'd1; id.rt = 5'd2; id.rd = 5'd3; id.pc4 = 32'h104;
    tick;
    chk("cap_funct", ex_funct, 6'b101010);
    chk("cap_aluop", ex_ALUOp, 2'b10);
    chk("cap_rdata1", ex_rdata1, 32'h5);
    chk("cap_rdata2", ex_rdata2, 32'h3);
    chk("cap_regwrite", ex_RegWrite, 1);
    chk("cap_valid", ex_valid, 1);
    stall = 1;
    id.r1 = 32'hAA; id.imm = 32'h7; id.op = 2'b01;
    tick; tick; tick;
    chk("stall_rdata1", ex_rdata1, 32'h5);
    chk("stall_funct", ex_funct, 6'b101010);
    stall = 0;
    tick;
    chk("unstall_rdata1", ex_rdata1, 32'hAA);
    chk("unstall_aluop", ex_ALUOp, 2'b01);
    chk("unstall_regwrite", ex_RegWrite, 1);
    stall = 1; flush = 1;
    tick;
    chk("flush_entry", dut_e, 0);
    stall = 0; flush = 0;
    id = '0; id.valid = 0; id.mw = 1; id.rw = 1; id.op = 2'b11; id.r1 = 32'h77;
    tick;
    chk("inv_memwrite", ex_MemWrite, 0);
    chk("inv_regwrite", ex_RegWrite, 0);
    chk("inv_valid", ex_valid, 0);
    chk("inv_aluop", ex_ALUOp, 0);
    chk("inv_rdata1", ex_rdata1, 32'h77);
    // lw $8 in EX, add using $8 in ID
    id = '0; id.valid = 1; id.mr = 1; id.mtr = 1; id.rw = 1; id.as = 1; id.rt = 5'd8; id.rs = 5'd4;
    tick;
    id = '0; id.valid = 1; id.rw = 1; id.rdst = 1; id.op = 2'b10; id.rs = 5'd8; id.rt = 5'd9; id.r1 = 32'h11;
    #1 chk("lu_stall_out", stall_out, LU);
    tick;
    chk("lu_valid", ex_valid, !LU);
    chk("lu_rdata1", ex_rdata1, LU ? 32'h0 : 32'h11);
    id = '0; id.valid = 1; id.mr = 1; id.as = 1; id.rt = 5'd0;
    tick;
    id = '0; id.valid = 1; id.rw = 1; id.rs = 5'd0; id.rt = 5'd0;
    #1 chk("lu_r0_stall_out", stall_out, 0);
    tick;
    chk("lu_r0_valid", ex_valid, 1);
    for (int i = 0; i < 40; i++) begin
      id = {$urandom, $urandom, $urandom, $urandom, $urandom};
      id.rs = 5'($urandom_range(0, 3));
      id.rt = 5'($urandom_range(0, 3));
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 5) == 0);
      tick;
    end
    stall = 0; flush = 0;
    id = '0; id.valid = 1; id.rw = 1; id.imm = 32'h3C;
    tick;
    chk("pre_arst_valid", ex_valid, 1);
    #2 rst_n = 0;
    #1 chk("arst_entry", dut_e, 0);
    chk("arst_stall_out", stall_out, 0);
    tick;
    chk("arst_hold", dut_e, 0);
    rst_n = 1;
    tick;
    chk("post_arst_funct", ex_funct, 6'h3C);
    run = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS pipeline; sits directly upstream of the EX-stage ALU control decode and the ALU.
- Captures decoded control bits, register operands, immediate and register numbers at the end of ID.
- Presents them to EX one cycle later: ALUOp and the 6-bit funct field feed ALU control; the remaining fields feed the operand muxes, ALU, MEM and WB.
- Supports stall (hold), flush (bubble insertion) and a valid tag per entry.

Parameters:
- DATA_W, 32, width of register operands, immediate and PC+4
- REG_W, 5, width of register specifiers

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold current EX contents (hazard unit)
- flush  in  1  replace next EX contents with a bubble (branch taken / exception)
- id_valid  in  1  ID stage holds a real instruction
- id_RegWrite, id_MemtoReg, id_MemRead, id_MemWrite, id_Branch, id_ALUSrc, id_RegDst  in  1 each  decoded control
- id_ALUOp  in  2  ALU op class (00 add, 01 sub, 10 R-type funct, 11 and)
- id_pc4  in  DATA_W  PC+4 of ID instruction
- id_rdata1, id_rdata2  in  DATA_W  register file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_rs, id_rt, id_rd  in  REG_W  register specifiers
- ex_* outputs  out  same widths  registered copies of every id_* input above (ex_valid, ex_RegWrite, ... ex_rd)
- ex_funct  out  6  ex_imm[5:0], funct field for ALU control
- stall_out  out  1  load-use stall request (optional feature only; tied 0 otherwise)

Behaviour:
- Single clock domain; all ex_* state updates on rising clk only.
- Reset (rst_n=0, asynchronous): every ex_* output = 0, stall_out = 0. An all-zero entry is a bubble: ex_valid=0, ALUOp=00, no RegWrite/MemWrite/MemRead/Branch.
- Release of rst_n is sampled on clk; the first capture occurs on the first rising edge with rst_n=1.
- Per-edge update priority:
  1. flush=1: load bubble. All control bits and ex_valid = 0. Data fields (pc4, rdata, imm, rs/rt/rd) are also cleared to 0 for deterministic traces.
  2. else stall=1: hold all ex_* unchanged.
  3. else capture all id_* into ex_*; ex_valid = id_valid.
- If id_valid=0 on capture, control bits are forced to 0 regardless of id_* control values (no side effects from invalid slots).
- Latency: exactly 1 cycle from id_* to ex_*.
- ex_funct is combinational from ex_imm[5:0]; no extra register.
- Simultaneous stall and flush: flush wins.
- Reset asserted mid-operation: immediate clear independent of clk, stall or flush.
- No arithmetic; widths pass through unchanged.

Optional Feature:
- Macro: ID_EX_LOAD_USE_EN.
- Defined:
  - stall_out = ex_valid & ex_MemRead & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (ex_rt == id_rt & ~id_ALUSrc)). Combinational from registered EX state and current ID inputs.
  - When stall_out=1 and flush=0, the block captures a bubble (as in flush) rather than the ID instruction. The external hazard unit holds IF/ID via stall_out.
  - The external stall input still holds EX when stall_out=0.
- Undefined: stall_out tied 0; load-use handling is entirely external.

Test Plan:
- Reset: drive inputs nonzero, assert rst_n=0 between edges -> all ex_* = 0 immediately, ex_ALUOp=00, ex_valid=0.
- Capture: id_ALUOp=10, id_imm=0x0000_002A, id_rdata1=0x5, id_rdata2=0x3, id_valid=1, RegWrite=1 -> next edge ex_funct=6'b101010, ex_ALUOp=10, ex_rdata1=0x5, ex_RegWrite=1, ex_valid=1.
- Stall: after capture, stall=1 for 3 edges with new id_* values -> ex_* unchanged; stall=0 -> new values appear on the next edge.
- Flush priority: stall=1 and flush=1 on the same edge, ex_RegWrite=1 -> next edge all ex_* = 0.
- Invalid slot: id_valid=0, id_MemWrite=1, id_RegWrite=1 -> ex_MemWrite=0, ex_RegWrite=0, ex_valid=0.
- Load-use (ID_EX_LOAD_USE_EN): EX holds lw with rt=8; ID has add with rs=8, id_valid=1 -> stall_out=1 and next edge is a bubble. Same case with rt=0 -> stall_out=0.
